// File: rtl/issue_select_scheduler_if.sv
// Dispatch, wakeup, flush and issue signals for one reservation station.
// master = upstream/environment side, slave = the scheduler itself.
interface issue_select_scheduler_if #(
  parameter int ENTRIES       = 8,
  parameter int PHY_WIDTH     = 6,
  parameter int ROB_WIDTH     = 5,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int NUM_WAKEUP    = 3
);
  localparam int OCC_WIDTH = $clog2(ENTRIES + 1);

  logic                            flush;
  logic                            dispatch_valid;
  logic                            dispatch_ready;
  logic [ROB_WIDTH-1:0]            dispatch_rob_id;
  logic [PHY_WIDTH-1:0]            dispatch_rs1_phy;
  logic                            dispatch_rs1_rdy;
  logic [PHY_WIDTH-1:0]            dispatch_rs2_phy;
  logic                            dispatch_rs2_rdy;
  logic [PAYLOAD_WIDTH-1:0]        dispatch_payload;
  logic [NUM_WAKEUP-1:0]           wakeup_valid;
  logic [NUM_WAKEUP*PHY_WIDTH-1:0] wakeup_phy;
  logic                            fu_busy;
  logic                            issue_valid;
  logic [ROB_WIDTH-1:0]            issue_rob_id;
  logic [PHY_WIDTH-1:0]            issue_rs1_phy;
  logic [PHY_WIDTH-1:0]            issue_rs2_phy;
  logic [PAYLOAD_WIDTH-1:0]        issue_payload;
  logic [OCC_WIDTH-1:0]            occupancy;

  modport master (
    output flush, dispatch_valid, dispatch_rob_id, dispatch_rs1_phy, dispatch_rs1_rdy,
           dispatch_rs2_phy, dispatch_rs2_rdy, dispatch_payload, wakeup_valid, wakeup_phy,
           fu_busy,
    input  dispatch_ready, issue_valid, issue_rob_id, issue_rs1_phy, issue_rs2_phy,
           issue_payload, occupancy
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_rob_id, dispatch_rs1_phy, dispatch_rs1_rdy,
           dispatch_rs2_phy, dispatch_rs2_rdy, dispatch_payload, wakeup_valid, wakeup_phy,
           fu_busy,
    output dispatch_ready, issue_valid, issue_rob_id, issue_rs1_phy, issue_rs2_phy,
           issue_payload, occupancy
  );
endinterface

// File: rtl/issue_select_scheduler.sv
// Reservation station with tag wakeup and oldest-ready select; the winner is
// presented as a registered one-cycle issue pulse.
module issue_select_scheduler #(
  parameter int ENTRIES       = 8,
  parameter int PHY_WIDTH     = 6,
  parameter int ROB_WIDTH     = 5,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int NUM_WAKEUP    = 3
) (
  input logic                     clk,
  input logic                     rst,
  issue_select_scheduler_if.slave bus
);
  localparam int OCC_WIDTH = $clog2(ENTRIES + 1);

  logic                            flush;
  logic                            dispatch_valid;
  logic [ROB_WIDTH-1:0]            dispatch_rob_id;
  logic [PHY_WIDTH-1:0]            dispatch_rs1_phy;
  logic                            dispatch_rs1_rdy;
  logic [PHY_WIDTH-1:0]            dispatch_rs2_phy;
  logic                            dispatch_rs2_rdy;
  logic [PAYLOAD_WIDTH-1:0]        dispatch_payload;
  logic [NUM_WAKEUP-1:0]           wakeup_valid;
  logic [NUM_WAKEUP*PHY_WIDTH-1:0] wakeup_phy;
  logic                            fu_busy;

  assign flush            = bus.flush;
  assign dispatch_valid   = bus.dispatch_valid;
  assign dispatch_rob_id  = bus.dispatch_rob_id;
  assign dispatch_rs1_phy = bus.dispatch_rs1_phy;
  assign dispatch_rs1_rdy = bus.dispatch_rs1_rdy;
  assign dispatch_rs2_phy = bus.dispatch_rs2_phy;
  assign dispatch_rs2_rdy = bus.dispatch_rs2_rdy;
  assign dispatch_payload = bus.dispatch_payload;
  assign wakeup_valid     = bus.wakeup_valid;
  assign wakeup_phy       = bus.wakeup_phy;
  assign fu_busy          = bus.fu_busy;

  // Per-entry control state
  logic [ENTRIES-1:0]       valid_reg, valid_next;
  logic [ENTRIES-1:0]       rs1_rdy_reg, rs1_rdy_next;
  logic [ENTRIES-1:0]       rs2_rdy_reg, rs2_rdy_next;
  logic [ENTRIES-1:0]       older_reg  [ENTRIES];
  logic [ENTRIES-1:0]       older_next [ENTRIES];
  logic [OCC_WIDTH-1:0]     occupancy_reg, occupancy_next;

  // Per-entry data storage, never reset: validity lives in valid_reg
  logic [ROB_WIDTH-1:0]     rob_id_reg  [ENTRIES];
  logic [PHY_WIDTH-1:0]     rs1_phy_reg [ENTRIES];
  logic [PHY_WIDTH-1:0]     rs2_phy_reg [ENTRIES];
  logic [PAYLOAD_WIDTH-1:0] payload_reg [ENTRIES];

  logic                     issue_valid_reg;
  logic [ROB_WIDTH-1:0]     issue_rob_id_reg;
  logic [PHY_WIDTH-1:0]     issue_rs1_phy_reg;
  logic [PHY_WIDTH-1:0]     issue_rs2_phy_reg;
  logic [PAYLOAD_WIDTH-1:0] issue_payload_reg;

  logic [ENTRIES-1:0]       ready_vec;
  logic [ENTRIES-1:0]       grant_vec;
  logic [ENTRIES-1:0]       alloc_onehot;
  logic [ENTRIES-1:0]       rs1_wake_vec;
  logic [ENTRIES-1:0]       rs2_wake_vec;
  logic                     dispatch_ready;
  logic                     accept;
  logic                     select;
  logic                     disp_rs1_rdy;
  logic                     disp_rs2_rdy;
  logic [ROB_WIDTH-1:0]     win_rob_id;
  logic [PHY_WIDTH-1:0]     win_rs1_phy;
  logic [PHY_WIDTH-1:0]     win_rs2_phy;
  logic [PAYLOAD_WIDTH-1:0] win_payload;

  function automatic logic tag_woken(
    input logic [PHY_WIDTH-1:0]            tag,
    input logic [NUM_WAKEUP-1:0]           wv,
    input logic [NUM_WAKEUP*PHY_WIDTH-1:0] wp
  );
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < NUM_WAKEUP; b++) begin
      if (wv[b] && (wp[b*PHY_WIDTH +: PHY_WIDTH] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic blocked;

      assign rs1_wake_vec[gi] = tag_woken(rs1_phy_reg[gi], wakeup_valid, wakeup_phy);
      assign rs2_wake_vec[gi] = tag_woken(rs2_phy_reg[gi], wakeup_valid, wakeup_phy);
      assign ready_vec[gi]    = valid_reg[gi] && rs1_rdy_reg[gi] && rs2_rdy_reg[gi];

      // An entry wins only if no other ready entry is older than it
      always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < ENTRIES; j++) begin
          if ((j != gi) && ready_vec[j] && older_reg[j][gi]) blocked = 1'b1;
        end
      end

      assign grant_vec[gi] = ready_vec[gi] && !blocked;
    end
  endgenerate

  assign dispatch_ready = (occupancy_reg < OCC_WIDTH'(ENTRIES)) && !flush;
  assign accept         = dispatch_valid && dispatch_ready;
  assign select         = (|ready_vec) && !fu_busy && !flush;
  assign disp_rs1_rdy   = dispatch_rs1_rdy || (dispatch_rs1_phy == '0) ||
                          tag_woken(dispatch_rs1_phy, wakeup_valid, wakeup_phy);
  assign disp_rs2_rdy   = dispatch_rs2_rdy || (dispatch_rs2_phy == '0) ||
                          tag_woken(dispatch_rs2_phy, wakeup_valid, wakeup_phy);

  // Lowest-index free slot; the descending scan leaves the lowest one set
  always_comb begin
    alloc_onehot = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        alloc_onehot    = '0;
        alloc_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    win_rob_id  = '0;
    win_rs1_phy = '0;
    win_rs2_phy = '0;
    win_payload = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant_vec[i]) begin
        win_rob_id  = rob_id_reg[i];
        win_rs1_phy = rs1_phy_reg[i];
        win_rs2_phy = rs2_phy_reg[i];
        win_payload = payload_reg[i];
      end
    end
  end

  always_comb begin
    valid_next     = valid_reg;
    rs1_rdy_next   = rs1_rdy_reg | (rs1_wake_vec & valid_reg);
    rs2_rdy_next   = rs2_rdy_reg | (rs2_wake_vec & valid_reg);
    older_next     = older_reg;
    occupancy_next = occupancy_reg + OCC_WIDTH'(accept) - OCC_WIDTH'(select);
    if (select) valid_next = valid_next & ~grant_vec;
    if (accept) begin
      valid_next = valid_next | alloc_onehot;
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_onehot[i]) begin
          rs1_rdy_next[i] = disp_rs1_rdy;
          rs2_rdy_next[i] = disp_rs2_rdy;
          // New entry is older than nobody; every currently valid entry is older than it
          older_next[i] = '0;
          for (int j = 0; j < ENTRIES; j++) older_next[j][i] = valid_reg[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg         <= '0;
      rs1_rdy_reg       <= '0;
      rs2_rdy_reg       <= '0;
      for (int i = 0; i < ENTRIES; i++) older_reg[i] <= '0;
      occupancy_reg     <= '0;
      issue_valid_reg   <= 1'b0;
      issue_rob_id_reg  <= '0;
      issue_rs1_phy_reg <= '0;
      issue_rs2_phy_reg <= '0;
      issue_payload_reg <= '0;
    end else if (flush) begin
      valid_reg       <= '0;
      for (int i = 0; i < ENTRIES; i++) older_reg[i] <= '0;
      occupancy_reg   <= '0;
      issue_valid_reg <= 1'b0;
    end else begin
      valid_reg       <= valid_next;
      rs1_rdy_reg     <= rs1_rdy_next;
      rs2_rdy_reg     <= rs2_rdy_next;
      older_reg       <= older_next;
      occupancy_reg   <= occupancy_next;
      issue_valid_reg <= select;
      if (select) begin
        issue_rob_id_reg  <= win_rob_id;
        issue_rs1_phy_reg <= win_rs1_phy;
        issue_rs2_phy_reg <= win_rs2_phy;
        issue_payload_reg <= win_payload;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_onehot[i]) begin
          rob_id_reg[i]  <= dispatch_rob_id;
          rs1_phy_reg[i] <= dispatch_rs1_phy;
          rs2_phy_reg[i] <= dispatch_rs2_phy;
          payload_reg[i] <= dispatch_payload;
        end
      end
    end
  end

  assign bus.dispatch_ready = dispatch_ready;
  assign bus.issue_valid    = issue_valid_reg;
  assign bus.issue_rob_id   = issue_rob_id_reg;
  assign bus.issue_rs1_phy  = issue_rs1_phy_reg;
  assign bus.issue_rs2_phy  = issue_rs2_phy_reg;
  assign bus.issue_payload  = issue_payload_reg;
  assign bus.occupancy      = occupancy_reg;
endmodule

// File: tb/tb_issue_select_scheduler.sv
// Directed bench for issue_select_scheduler: one task per scenario, inline checks.
module tb_issue_select_scheduler;
  localparam int ENTRIES       = 8;
  localparam int PHY_WIDTH     = 6;
  localparam int ROB_WIDTH     = 5;
  localparam int PAYLOAD_WIDTH = 64;
  localparam int NUM_WAKEUP    = 3;

  logic clk;
  logic rst;
  int   checks_total;
  int   checks_passed;

  issue_select_scheduler_if #(
    .ENTRIES(ENTRIES), .PHY_WIDTH(PHY_WIDTH), .ROB_WIDTH(ROB_WIDTH),
    .PAYLOAD_WIDTH(PAYLOAD_WIDTH), .NUM_WAKEUP(NUM_WAKEUP)
  ) bus ();

  issue_select_scheduler #(
    .ENTRIES(ENTRIES), .PHY_WIDTH(PHY_WIDTH), .ROB_WIDTH(ROB_WIDTH),
    .PAYLOAD_WIDTH(PAYLOAD_WIDTH), .NUM_WAKEUP(NUM_WAKEUP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush            = 1'b0;
    bus.dispatch_valid   = 1'b0;
    bus.dispatch_rob_id  = '0;
    bus.dispatch_rs1_phy = '0;
    bus.dispatch_rs1_rdy = 1'b0;
    bus.dispatch_rs2_phy = '0;
    bus.dispatch_rs2_rdy = 1'b0;
    bus.dispatch_payload = '0;
    bus.wakeup_valid     = '0;
    bus.wakeup_phy       = '0;
    bus.fu_busy          = 1'b0;
  endtask

  task automatic set_dispatch(input logic [4:0] rob, input logic [5:0] t1, input logic r1,
                              input logic [5:0] t2, input logic r2);
    bus.dispatch_valid   = 1'b1;
    bus.dispatch_rob_id  = rob;
    bus.dispatch_rs1_phy = t1;
    bus.dispatch_rs1_rdy = r1;
    bus.dispatch_rs2_phy = t2;
    bus.dispatch_rs2_rdy = r2;
    bus.dispatch_payload = 64'hFEED_0000_0000_0000 | 64'(rob);
  endtask

  task automatic test_reset();
    checks_total++; if (bus.occupancy !== 4'd0) $display("FAIL reset_occ: got %0d expected 0", bus.occupancy); else checks_passed++;
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %0b expected 0", bus.issue_valid); else checks_passed++;
    checks_total++; if (bus.issue_rob_id !== 5'd0) $display("FAIL reset_rob: got %0d expected 0", bus.issue_rob_id); else checks_passed++;
    checks_total++; if (bus.issue_payload !== 64'd0) $display("FAIL reset_payload: got %0h expected 0", bus.issue_payload); else checks_passed++;
    checks_total++; if (bus.dispatch_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", bus.dispatch_ready); else checks_passed++;
    $display("reset: occupancy=%0d issue_valid=%0b", bus.occupancy, bus.issue_valid);
  endtask

  task automatic test_single_issue();
    set_dispatch(5'd3, 6'd5, 1'b1, 6'd6, 1'b1);
    tick();
    bus.dispatch_valid = 1'b0;
    checks_total++; if (bus.occupancy !== 4'd1) $display("FAIL single_occ1: got %0d expected 1", bus.occupancy); else checks_passed++;
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL single_early: got %0b expected 0", bus.issue_valid); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", bus.issue_valid); else checks_passed++;
    checks_total++; if (bus.issue_rob_id !== 5'd3) $display("FAIL single_rob: got %0d expected 3", bus.issue_rob_id); else checks_passed++;
    checks_total++; if (bus.issue_rs1_phy !== 6'd5 || bus.issue_rs2_phy !== 6'd6) $display("FAIL single_tags: got %0d,%0d expected 5,6", bus.issue_rs1_phy, bus.issue_rs2_phy); else checks_passed++;
    checks_total++; if (bus.issue_payload !== 64'hFEED_0000_0000_0003) $display("FAIL single_payload: got %0h expected feed000000000003", bus.issue_payload); else checks_passed++;
    checks_total++; if (bus.occupancy !== 4'd0) $display("FAIL single_occ0: got %0d expected 0", bus.occupancy); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL single_pulse: got %0b expected 0", bus.issue_valid); else checks_passed++;
    $display("single_issue: rob 3 issued");
  endtask

  task automatic test_wakeup_order();
    set_dispatch(5'd1, 6'd12, 1'b0, 6'd0, 1'b0);
    tick();
    set_dispatch(5'd2, 6'd3, 1'b1, 6'd4, 1'b1);
    tick();
    bus.dispatch_valid = 1'b0;
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL wake_none: got %0b expected 0", bus.issue_valid); else checks_passed++;
    bus.wakeup_valid = 3'b010;
    bus.wakeup_phy   = {6'd0, 6'd12, 6'd0};
    tick();
    bus.wakeup_valid = '0;
    checks_total++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 5'd2) $display("FAIL wake_first: got v=%0b rob=%0d expected v=1 rob=2", bus.issue_valid, bus.issue_rob_id); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 5'd1) $display("FAIL wake_second: got v=%0b rob=%0d expected v=1 rob=1", bus.issue_valid, bus.issue_rob_id); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 4'd0) $display("FAIL wake_drain: got v=%0b occ=%0d expected v=0 occ=0", bus.issue_valid, bus.occupancy); else checks_passed++;
    $display("wakeup_order: rob 2 then rob 1");
  endtask

  task automatic test_age_order();
    bus.fu_busy = 1'b1;
    set_dispatch(5'd9, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    set_dispatch(5'd5, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    bus.dispatch_valid = 1'b0;
    bus.fu_busy = 1'b0;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 5'd9) $display("FAIL age_rob9: got v=%0b rob=%0d expected v=1 rob=9", bus.issue_valid, bus.issue_rob_id); else checks_passed++;
    bus.fu_busy = 1'b1;
    set_dispatch(5'd7, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    bus.dispatch_valid = 1'b0;
    bus.fu_busy = 1'b0;
    checks_total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 4'd2) $display("FAIL age_hold: got v=%0b occ=%0d expected v=0 occ=2", bus.issue_valid, bus.occupancy); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 5'd5) $display("FAIL age_rob5: got v=%0b rob=%0d expected v=1 rob=5", bus.issue_valid, bus.issue_rob_id); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 5'd7) $display("FAIL age_rob7: got v=%0b rob=%0d expected v=1 rob=7", bus.issue_valid, bus.issue_rob_id); else checks_passed++;
    tick();
    $display("age_order: rob 5 before rob 7");
  endtask

  task automatic test_full();
    for (int i = 0; i < ENTRIES; i++) begin
      set_dispatch(5'(i), 6'd20, 1'b0, 6'd0, 1'b0);
      tick();
    end
    bus.dispatch_valid = 1'b0;
    checks_total++; if (bus.dispatch_ready !== 1'b0) $display("FAIL full_ready: got %0b expected 0", bus.dispatch_ready); else checks_passed++;
    checks_total++; if (bus.occupancy !== 4'd8) $display("FAIL full_occ: got %0d expected 8", bus.occupancy); else checks_passed++;
    set_dispatch(5'd15, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    bus.dispatch_valid = 1'b0;
    checks_total++; if (bus.occupancy !== 4'd8 || bus.issue_valid !== 1'b0) $display("FAIL full_drop: got occ=%0d v=%0b expected occ=8 v=0", bus.occupancy, bus.issue_valid); else checks_passed++;
    bus.wakeup_valid = 3'b001;
    bus.wakeup_phy   = {6'd0, 6'd0, 6'd20};
    tick();
    bus.wakeup_valid = '0;
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL full_same_cycle: got %0b expected 0", bus.issue_valid); else checks_passed++;
    for (int i = 0; i < ENTRIES; i++) begin
      tick();
      checks_total++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 5'(i)) $display("FAIL full_issue%0d: got v=%0b rob=%0d expected v=1 rob=%0d", i, bus.issue_valid, bus.issue_rob_id, i); else checks_passed++;
    end
    tick();
    checks_total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 4'd0) $display("FAIL full_drain: got v=%0b occ=%0d expected v=0 occ=0", bus.issue_valid, bus.occupancy); else checks_passed++;
    $display("full: 8 issued in age order, rob 15 dropped");
  endtask

  task automatic test_fu_busy();
    bus.fu_busy = 1'b1;
    set_dispatch(5'd11, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL busy_a: got %0b expected 0", bus.issue_valid); else checks_passed++;
    set_dispatch(5'd12, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    bus.dispatch_valid = 1'b0;
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL busy_b: got %0b expected 0", bus.issue_valid); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 4'd2) $display("FAIL busy_c: got v=%0b occ=%0d expected v=0 occ=2", bus.issue_valid, bus.occupancy); else checks_passed++;
    bus.fu_busy = 1'b0;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 5'd11) $display("FAIL busy_rob11: got v=%0b rob=%0d expected v=1 rob=11", bus.issue_valid, bus.issue_rob_id); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 5'd12) $display("FAIL busy_rob12: got v=%0b rob=%0d expected v=1 rob=12", bus.issue_valid, bus.issue_rob_id); else checks_passed++;
    tick();
    $display("fu_busy: held, then rob 11 and rob 12");
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      set_dispatch(5'(i), 6'd40, 1'b0, 6'd0, 1'b0);
      tick();
    end
    checks_total++; if (bus.occupancy !== 4'd3) $display("FAIL flush_pre_occ: got %0d expected 3", bus.occupancy); else checks_passed++;
    bus.flush = 1'b1;
    set_dispatch(5'd4, 6'd1, 1'b1, 6'd2, 1'b1);
    #1;
    checks_total++; if (bus.dispatch_ready !== 1'b0) $display("FAIL flush_ready: got %0b expected 0", bus.dispatch_ready); else checks_passed++;
    tick();
    bus.flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    checks_total++; if (bus.occupancy !== 4'd0 || bus.issue_valid !== 1'b0) $display("FAIL flush_clear: got occ=%0d v=%0b expected occ=0 v=0", bus.occupancy, bus.issue_valid); else checks_passed++;
    checks_total++; if (bus.issue_rob_id !== 5'd12) $display("FAIL flush_hold: got %0d expected 12", bus.issue_rob_id); else checks_passed++;
    bus.wakeup_valid = 3'b100;
    bus.wakeup_phy   = {6'd40, 12'd0};
    tick();
    bus.wakeup_valid = '0;
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL flush_dropped: got %0b expected 0", bus.issue_valid); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 4'd0) $display("FAIL flush_gone: got v=%0b occ=%0d expected v=0 occ=0", bus.issue_valid, bus.occupancy); else checks_passed++;
    $display("flush: station cleared, rob 4 ignored");
  endtask

  task automatic test_reset_mid();
    set_dispatch(5'd6, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    bus.dispatch_valid = 1'b0;
    checks_total++; if (bus.occupancy !== 4'd1) $display("FAIL rstmid_occ1: got %0d expected 1", bus.occupancy); else checks_passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks_total++; if (bus.occupancy !== 4'd0 || bus.issue_valid !== 1'b0) $display("FAIL rstmid_clear: got occ=%0d v=%0b expected occ=0 v=0", bus.occupancy, bus.issue_valid); else checks_passed++;
    checks_total++; if (bus.issue_rob_id !== 5'd0) $display("FAIL rstmid_rob: got %0d expected 0", bus.issue_rob_id); else checks_passed++;
    tick();
    checks_total++; if (bus.issue_valid !== 1'b0) $display("FAIL rstmid_gone: got %0b expected 0", bus.issue_valid); else checks_passed++;
    $display("reset_mid: station cleared");
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks_total  = 0;
    checks_passed = 0;
    clear_inputs();
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_single_issue();
    test_wakeup_order();
    test_age_order();
    test_full();
    test_fu_busy();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
